// File: rtl/escalonador_programas.sv
// Round-robin context-switch controller: preempts the running program on quantum
// expiry or yield, saves its PC into dados_RAM and reloads the next program's PC.
module escalonador_programas #(
   parameter int DATA_WIDTH    = 32,
   parameter int QUANTUM       = 1000,
   parameter int NUM_PROGRAMAS = 5,
   parameter int BASE_STRIDE   = 1000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  troca_forcada,
   input  logic [DATA_WIDTH-1:0] pc_atual,
   input  logic [DATA_WIDTH-1:0] q_ram,
   output logic                  halt_cpu,
   output logic                  spc,
   output logic                  lpc,
   output logic                  nextProgram,
   output logic [DATA_WIDTH-1:0] enderecoSpc,
   output logic                  pc_carregar,
   output logic [DATA_WIDTH-1:0] pc_novo,
   output logic [2:0]            programa_atual,
   output logic                  em_troca,
   output logic [2:0]            estado_dbg
);

   localparam int CW = $clog2(QUANTUM);

   typedef enum logic [2:0] {
      EXECUTA = 3'd0,
      SALVA   = 3'd1,
      AVANCA  = 3'd2,
      CARREGA = 3'd3,
      LE      = 3'd4,
      RETOMA  = 3'd5
   } estado_t;

   estado_t               estado_q, estado_d;
   logic [CW-1:0]         contador_q, contador_d;
   logic [2:0]            programa_q, programa_d;
   logic [DATA_WIDTH-1:0] endereco_q, endereco_d;
   logic [DATA_WIDTH-1:0] pc_novo_q, pc_novo_d;
   logic                  gatilho;

   // Decision is only taken while running; yields outside EXECUTA are dropped.
   assign gatilho = (estado_q == EXECUTA) && enable &&
                    (troca_forcada || (contador_q == CW'(QUANTUM - 1)));

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= EXECUTA;
         contador_q <= '0;
         programa_q <= 3'd1;
         endereco_q <= '0;
         pc_novo_q  <= '0;
      end else begin
         estado_q   <= estado_d;
         contador_q <= contador_d;
         programa_q <= programa_d;
         endereco_q <= endereco_d;
         pc_novo_q  <= pc_novo_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      contador_d = contador_q;
      programa_d = programa_q;
      endereco_d = endereco_q;
      pc_novo_d  = pc_novo_q;
      case (estado_q)
         EXECUTA: begin
            if (gatilho) begin
               endereco_d = pc_atual;
               estado_d   = SALVA;
            end else if (enable) begin
               contador_d = contador_q + CW'(1);
            end
         end
         SALVA:   estado_d = AVANCA;
         AVANCA: begin
            // Must track the RAM's own program counter, which advances on this edge.
            programa_d = (programa_q == 3'(NUM_PROGRAMAS)) ? 3'd1 : programa_q + 3'd1;
            estado_d   = CARREGA;
         end
         CARREGA: estado_d = LE;
         LE: begin
            pc_novo_d = q_ram + DATA_WIDTH'(programa_q) * DATA_WIDTH'(BASE_STRIDE);
            estado_d  = RETOMA;
         end
         RETOMA: begin
            contador_d = '0;
            estado_d   = EXECUTA;
         end
         default: estado_d = EXECUTA;
      endcase
   end

   assign halt_cpu       = (estado_q != EXECUTA) || gatilho;
   assign spc            = (estado_q == SALVA);
   assign nextProgram    = (estado_q == AVANCA);
   assign lpc            = (estado_q == CARREGA);
   assign pc_carregar    = (estado_q == RETOMA);
   assign em_troca       = (estado_q != EXECUTA);
   assign enderecoSpc    = endereco_q;
   assign pc_novo        = pc_novo_q;
   assign programa_atual = programa_q;
   assign estado_dbg     = estado_q;

endmodule

// File: tb/tb_escalonador_programas.sv
// Bench for escalonador_programas: fixed vector table, directed corner sequences and
// random stimulus against a transaction-level model, with a dados_RAM stand-in.
module tb_escalonador_programas;

   localparam int Q    = 8;
   localparam int BASE = 1000;
   localparam int NP   = 5;

   logic        clock = 1'b0;
   logic        reset, enable, troca_forcada;
   logic [31:0] pc_atual, q_ram;
   logic        halt_cpu, spc, lpc, nextProgram, pc_carregar, em_troca;
   logic [31:0] enderecoSpc, pc_novo;
   logic [2:0]  programa_atual, estado_dbg;

   escalonador_programas #(
      .DATA_WIDTH(32), .QUANTUM(Q), .NUM_PROGRAMAS(NP), .BASE_STRIDE(BASE)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .troca_forcada(troca_forcada),
      .pc_atual(pc_atual), .q_ram(q_ram), .halt_cpu(halt_cpu), .spc(spc), .lpc(lpc),
      .nextProgram(nextProgram), .enderecoSpc(enderecoSpc), .pc_carregar(pc_carregar),
      .pc_novo(pc_novo), .programa_atual(programa_atual), .em_troca(em_troca),
      .estado_dbg(estado_dbg)
   );

   always #5 clock = ~clock;

   // dados_RAM stand-in: per-program relative PC slots, program counter, registered q
   logic [31:0] seed_slot [0:7];
   logic [31:0] ram_slot  [0:7];
   logic [2:0]  rprog;

   always @(posedge clock) begin
      if (reset) begin
         rprog <= 3'd1;
         q_ram <= 32'd0;
         for (int i = 0; i < 8; i++) ram_slot[i] <= seed_slot[i];
      end else begin
         if (spc) ram_slot[rprog] <= enderecoSpc - 32'(rprog) * 32'(BASE);
         if (nextProgram) rprog <= (rprog == 3'(NP)) ? 3'd1 : rprog + 3'd1;
         if (lpc) q_ram <= ram_slot[rprog];
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: a pending list of switch actions is queued at each decision
   int          m_ph[$];
   int          m_prog, m_cnt;
   logic [31:0] m_end, m_pcn, m_q;
   logic [31:0] m_slot [0:7];
   bit          mv = 0;

   logic s_halt, s_spc, s_np, s_lpc, s_pcc, s_em;
   logic [2:0]  s_prog;
   logic [31:0] s_end, s_pcn;

   task automatic cycle(input logic r, input logic e, input logic t, input logic [31:0] p);
      int ph, act;
      bit trig;
      @(negedge clock);
      reset = r; enable = e; troca_forcada = t; pc_atual = p;
      #1;
      s_halt = halt_cpu; s_spc = spc; s_np = nextProgram; s_lpc = lpc;
      s_pcc = pc_carregar; s_em = em_troca; s_prog = programa_atual;
      s_end = enderecoSpc; s_pcn = pc_novo;
      ph   = (m_ph.size() == 0) ? 0 : m_ph[0];
      trig = (ph == 0) && e && (t || (m_cnt == Q - 1));
      if (mv) begin
         chk("halt_cpu", 32'(s_halt), 32'(ph != 0 || trig));
         chk("spc", 32'(s_spc), 32'(ph == 1));
         chk("nextProgram", 32'(s_np), 32'(ph == 2));
         chk("lpc", 32'(s_lpc), 32'(ph == 3));
         chk("pc_carregar", 32'(s_pcc), 32'(ph == 5));
         chk("em_troca", 32'(s_em), 32'(ph != 0));
         chk("programa_atual", 32'(s_prog), 32'(m_prog));
         chk("enderecoSpc", s_end, m_end);
         chk("pc_novo", s_pcn, m_pcn);
      end
      @(posedge clock);
      if (r) begin
         m_ph.delete();
         m_prog = 1; m_cnt = 0; m_end = 0; m_pcn = 0; m_q = 0;
         for (int i = 0; i < 8; i++) m_slot[i] = seed_slot[i];
         mv = 1;
      end else if (ph == 0) begin
         if (trig) begin
            m_end = p;
            m_ph  = '{1, 2, 3, 4, 5};
         end else if (e) begin
            m_cnt++;
         end
      end else begin
         act = m_ph.pop_front();
         case (act)
            1: m_slot[m_prog] = m_end - 32'(m_prog * BASE);
            2: m_prog = (m_prog == NP) ? 1 : m_prog + 1;
            3: m_q = m_slot[m_prog];
            4: m_pcn = m_q + 32'(m_prog * BASE);
            default: m_cnt = 0;
         endcase
      end
   endtask

   typedef struct {
      logic        r, e, t;
      logic [31:0] p;
      logic        ck;
      logic        h, sp, np, lp, pc;
      logic [2:0]  pr;
      logic [31:0] ed, pn;
   } vec_t;

   vec_t tbl [16];

   initial begin
      bit any;
      reset = 1'b1; enable = 1'b0; troca_forcada = 1'b0; pc_atual = 32'd0;
      for (int i = 0; i < 8; i++) seed_slot[i] = 32'd0;

      // Quantum expiry from reset with pc_atual=1042
      tbl[0] = '{1, 0, 0, 32'd0,    0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0};
      tbl[1] = '{1, 0, 0, 32'd0,    1, 0, 0, 0, 0, 0, 3'd1, 32'd0, 32'd0};
      for (int i = 2; i < 9; i++)
         tbl[i] = '{0, 1, 0, 32'd1042, 1, 0, 0, 0, 0, 0, 3'd1, 32'd0, 32'd0};
      tbl[9]  = '{0, 1, 0, 32'd1042, 1, 1, 0, 0, 0, 0, 3'd1, 32'd0,    32'd0};
      tbl[10] = '{0, 1, 0, 32'd1042, 1, 1, 1, 0, 0, 0, 3'd1, 32'd1042, 32'd0};
      tbl[11] = '{0, 1, 0, 32'd1042, 1, 1, 0, 1, 0, 0, 3'd1, 32'd1042, 32'd0};
      tbl[12] = '{0, 1, 0, 32'd1042, 1, 1, 0, 0, 1, 0, 3'd2, 32'd1042, 32'd0};
      tbl[13] = '{0, 1, 0, 32'd1042, 1, 1, 0, 0, 0, 0, 3'd2, 32'd1042, 32'd0};
      tbl[14] = '{0, 1, 0, 32'd1042, 1, 1, 0, 0, 0, 1, 3'd2, 32'd1042, 32'd2000};
      tbl[15] = '{0, 1, 0, 32'd2005, 1, 0, 0, 0, 0, 0, 3'd2, 32'd1042, 32'd2000};

      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].p);
         if (tbl[i].ck) begin
            chk("tbl_halt", 32'(s_halt), 32'(tbl[i].h));
            chk("tbl_spc", 32'(s_spc), 32'(tbl[i].sp));
            chk("tbl_next", 32'(s_np), 32'(tbl[i].np));
            chk("tbl_lpc", 32'(s_lpc), 32'(tbl[i].lp));
            chk("tbl_pcc", 32'(s_pcc), 32'(tbl[i].pc));
            chk("tbl_prog", 32'(s_prog), 32'(tbl[i].pr));
            chk("tbl_end", s_end, tbl[i].ed);
            chk("tbl_pcnovo", s_pcn, tbl[i].pn);
         end
      end

      // Round trip through programs 2..5 back to 1, whose saved PC is 1042
      for (int i = 0; i < 51; i++)
         cycle(0, 1, 0, 32'(m_prog * BASE + 17 + i));
      chk("rt_pcc", 32'(s_pcc), 32'd1);
      chk("rt_prog", 32'(s_prog), 32'd1);
      chk("rt_pcnovo", s_pcn, 32'd1042);

      // Forced yield at contador=3; a second yield during CARREGA is ignored
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'd1100);
      cycle(0, 1, 1, 32'd1103);
      chk("fy_decision", 32'(s_halt), 32'd1);
      cycle(0, 1, 0, 32'd0);
      chk("fy_spc", 32'(s_spc), 32'd1);
      chk("fy_end", s_end, 32'd1103);
      cycle(0, 1, 0, 32'd0);
      cycle(0, 1, 1, 32'd0);
      chk("fy_lpc", 32'(s_lpc), 32'd1);
      cycle(0, 1, 0, 32'd0);
      cycle(0, 1, 0, 32'd0);
      chk("fy_pcc", 32'(s_pcc), 32'd1);
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, 32'd2300);
         chk("fy_requantum", 32'(s_halt), 32'(i == 7));
      end
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'd0);
      cycle(0, 1, 0, 32'd3000);
      chk("fy_no_extra", 32'(s_halt), 32'd0);

      // enable=0 freezes the quantum and ignores yields (contador now 1)
      for (int i = 0; i < 2; i++) cycle(0, 1, 0, 32'd3001);
      any = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, (i == 10), 32'd3003);
         any |= s_halt | s_spc | s_em;
      end
      chk("en0_quiet", 32'(any), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 0, 32'd3003);
         chk("en0_resume", 32'(s_halt), 32'(i == 4));
      end
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'd0);

      // Reset during CARREGA
      cycle(0, 1, 1, 32'd4010);
      cycle(0, 1, 0, 32'd0);
      cycle(0, 1, 0, 32'd0);
      cycle(1, 1, 0, 32'd0);
      chk("rst_in_carrega_lpc", 32'(s_lpc), 32'd1);
      cycle(0, 0, 0, 32'd0);
      chk("rst_em_troca", 32'(s_em), 32'd0);
      chk("rst_lpc", 32'(s_lpc), 32'd0);
      chk("rst_prog", 32'(s_prog), 32'd1);
      chk("rst_halt", 32'(s_halt), 32'd0);
      any = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 0, 32'd0);
         any |= s_pcc;
      end
      chk("rst_no_pcc", 32'(any), 32'd0);

      // Random stimulus with preloaded RAM slots
      for (int i = 0; i < 8; i++) seed_slot[i] = $urandom;
      cycle(1, 0, 0, 32'd0);
      cycle(1, 0, 0, 32'd0);
      for (int i = 0; i < 800; i++)
         cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 14) == 0), $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
